// File: rtl/uart_boot_receiver_pkg.sv
// Shared types and constants for the UART boot receiver.
// Reply codes, start marker default and FSM state encoding.
package uart_boot_receiver_pkg;

  localparam logic [7:0] START_DEF = 8'hFE;
  localparam logic [7:0] ST_ACK    = 8'h06;
  localparam logic [7:0] ST_NAK    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_STAT  = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/uart_boot_receiver_if.sv
// Byte streams to/from the UART core plus the firmware memory write bus.
// master = receiver side, slave = UART core / memory side.
interface uart_boot_receiver_if #(
  parameter int unsigned ADDR_W = 15
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_ready,
    output rx_ready, tx_data, tx_valid,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_ready,
    input  rx_ready, tx_data, tx_valid,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/uart_boot_packer.sv
// Byte-lane packer: assembles little-endian 32-bit words with strobes.
// Unwritten lanes stay zero so a short final word has clean padding.
module uart_boot_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [3:0]  strb_o,
  output logic        full_o
);

  logic [31:0] word_q;
  logic [3:0]  strb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      strb_q <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      strb_q <= '0;
    end else if (load_i) begin
      word_q[{lane_i, 3'b000} +: 8] <= byte_i;
      strb_q[lane_i]                <= 1'b1;
    end
  end

  assign word_o = word_q;
  assign strb_o = strb_q;
  assign full_o = load_i & (lane_i == 2'd3);

endmodule

// File: rtl/uart_boot_receiver.sv
// Framed file-download receiver: START, LEN[31:0] LE, payload -> RAM words.
// Replies ACK/NAK then an 8-bit payload checksum.
module uart_boot_receiver
  import uart_boot_receiver_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned BASE_ADDR  = 0,
  parameter logic [7:0]  START_BYTE = START_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_boot_receiver_if.master bus,
  output logic                 busy,
  output logic                 done
);

  // Largest payload that fits between BASE_ADDR and the top of memory
  localparam logic [32:0] CAP = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

  state_t            state_q;
  logic              arm_q;
  logic [31:0]       len_q;
  logic [31:0]       cnt_q;
  logic [1:0]        lcnt_q;
  logic [ADDR_W-3:0] widx_q;
  logic [7:0]        chk_q;
  logic [7:0]        tx_data_q;
  logic              disc_q;
  logic              mem_valid_q;
  logic              tx_valid_q;
  logic              done_q;

  logic        rx_fire;
  logic        last;
  logic        load;
  logic        clear;
  logic        full;
  logic [31:0] len_full;
  logic [31:0] cnt_nx;
  logic [31:0] word;
  logic [3:0]  strb;

  assign rx_fire  = bus.rx_valid & bus.rx_ready;
  assign len_full = {bus.rx_data, len_q[31:8]};
  assign cnt_nx   = cnt_q + 32'd1;
  assign last     = (cnt_nx == len_q);
  assign load     = rx_fire & (state_q == S_DATA) & ~disc_q;
  assign clear    = ((state_q == S_WRITE) & bus.mem_ready)
                  | (state_q == S_DONE);

  uart_boot_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .clear_i (clear),
    .lane_i  (cnt_q[1:0]),
    .byte_i  (bus.rx_data),
    .word_o  (word),
    .strb_o  (strb),
    .full_o  (full)
  );

  // arm_q keeps rx_ready low until the first edge after reset release
  assign bus.rx_ready  = arm_q
                       & (state_q inside {S_IDLE, S_LEN, S_DATA});
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = ADDR_W'(BASE_ADDR) + {widx_q, 2'b00};
  assign bus.mem_wdata = word;
  assign bus.mem_wstrb = strb;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      arm_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      lcnt_q      <= '0;
      widx_q      <= '0;
      chk_q       <= '0;
      tx_data_q   <= '0;
      disc_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      arm_q  <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire && bus.rx_data == START_BYTE) begin
            state_q <= S_LEN;
            lcnt_q  <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            chk_q   <= '0;
            disc_q  <= 1'b0;
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            len_q  <= len_full;
            lcnt_q <= lcnt_q + 2'd1;
            if (lcnt_q == 2'd3) begin
              if (len_full == 32'd0) begin
                state_q    <= S_STAT;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ST_ACK;
              end else begin
                state_q <= S_DATA;
                disc_q  <= ({1'b0, len_full} > CAP);
              end
            end
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            cnt_q <= cnt_nx;
            chk_q <= chk_q + bus.rx_data;
            if (disc_q) begin
              if (last) begin
                state_q    <= S_STAT;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ST_NAK;
              end
            end else if (full || last) begin
              state_q     <= S_WRITE;
              mem_valid_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            widx_q      <= widx_q + 1'b1;
            if (cnt_q == len_q) begin
              state_q    <= S_STAT;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ST_ACK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_STAT: begin
          if (bus.tx_ready) begin
            tx_data_q <= chk_q;
            state_q   <= S_CHK;
          end
        end
        S_CHK: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          len_q   <= '0;
          cnt_q   <= '0;
          lcnt_q  <= '0;
          widx_q  <= '0;
          chk_q   <= '0;
          disc_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_receiver.sv
// Randomized bench for uart_boot_receiver against a frame-level model.
// Two DUTs: a wide one at a nonzero base and a tiny one for size limits.
module tb_uart_boot_receiver;

  typedef logic [7:0] bq_t[$];
  typedef logic [50:0] wr_t;
  localparam int BASE0 = 'h40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       s  = 1'b0;
  logic       rv = 1'b0;
  logic       mr = 1'b0;
  logic       tr = 1'b0;
  logic [7:0] rd = 8'd0;

  uart_boot_receiver_if #(.ADDR_W(15)) b0 ();
  uart_boot_receiver_if #(.ADDR_W(6))  b1 ();
  logic busy0, done0, busy1, done1;

  uart_boot_receiver #(.ADDR_W(15), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .busy(busy0), .done(done0)
  );
  uart_boot_receiver #(.ADDR_W(6), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .busy(busy1), .done(done1)
  );

  assign b0.rx_valid  = rv & ~s;
  assign b0.rx_data   = rd;
  assign b0.mem_ready = mr & ~s;
  assign b0.tx_ready  = tr & ~s;
  assign b1.rx_valid  = rv & s;
  assign b1.rx_data   = rd;
  assign b1.mem_ready = mr & s;
  assign b1.tx_ready  = tr & s;

  logic        o_rr, o_mv, o_tv, o_busy, o_dn;
  logic [14:0] o_ma;
  logic [31:0] o_mw;
  logic [3:0]  o_ms;
  logic [7:0]  o_td;
  assign o_rr   = s ? b1.rx_ready  : b0.rx_ready;
  assign o_mv   = s ? b1.mem_valid : b0.mem_valid;
  assign o_tv   = s ? b1.tx_valid  : b0.tx_valid;
  assign o_busy = s ? busy1 : busy0;
  assign o_dn   = s ? done1 : done0;
  assign o_ma   = s ? {9'd0, b1.mem_addr} : b0.mem_addr;
  assign o_mw   = s ? b1.mem_wdata : b0.mem_wdata;
  assign o_ms   = s ? b1.mem_wstrb : b0.mem_wstrb;
  assign o_td   = s ? b1.tx_data : b0.tx_data;

  int n_err = 0;
  int n_chk = 0;
  int fid = 0;
  bq_t rxq;
  wr_t wq[$];
  wr_t ew[$];
  logic [7:0] tq[$];
  logic [7:0] et[$];
  int ndone, nrx, mwait, twait, mlo, mhi, tlo, thi;
  bit consumed = 0, mpend = 0, tpend = 0;
  logic [51:0] pm;
  logic [7:0] ptd;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s frame=%0d got=%0h exp=%0h", tag, fid, got, exp);
    end
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic bq_t rand_junk(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 253)));
    return q;
  endfunction

  // Frame-level reference: words, strobes, addresses and the reply pair
  task automatic model(input bit sel, input bq_t pay);
    int aw, base, len;
    longint cap;
    logic [7:0] sum;
    logic [31:0] d;
    logic [3:0] st;
    aw = sel ? 6 : 15;
    base = sel ? 0 : BASE0;
    cap = (64'sd1 <<< aw) - base;
    len = pay.size();
    sum = 8'd0;
    ew.delete();
    et.delete();
    foreach (pay[i]) sum += pay[i];
    if (len <= cap) begin
      for (int w = 0; 4 * w < len; w++) begin
        d = '0;
        st = '0;
        for (int k = 0; k < 4; k++) begin
          if (4 * w + k < len) begin
            d[8*k +: 8] = pay[4*w+k];
            st[k] = 1'b1;
          end
        end
        ew.push_back({15'(base + 4 * w), d, st});
      end
    end
    et.push_back((len <= cap) ? 8'h06 : 8'h15);
    et.push_back(sum);
  endtask

  // One clock of stimulus and observation, entered at a falling edge
  task automatic step();
    if (consumed) begin
      rv = 1'b0;
      consumed = 0;
    end
    if (!rv && rxq.size() > 0 && $urandom_range(0, 3) != 0) begin
      rv = 1'b1;
      rd = rxq[0];
    end
    mr = 1'b0;
    if (o_mv) begin
      if (mwait == 0) mr = 1'b1;
      else mwait--;
    end
    tr = 1'b0;
    if (o_tv) begin
      if (twait == 0) tr = 1'b1;
      else twait--;
    end
    #1;
    if (o_mv) check("rx_rdy_in_write", 64'(o_rr), 64'd0);
    if (mpend) check("mem_hold", 64'({o_mv, o_ma, o_mw, o_ms}), 64'(pm));
    if (tpend) check("tx_hold", 64'({o_tv, o_td}), 64'({1'b1, ptd}));
    if (rv && o_rr) begin
      void'(rxq.pop_front());
      consumed = 1;
      nrx++;
    end
    if (o_mv && mr) begin
      wq.push_back({o_ma, o_mw, o_ms});
      mwait = $urandom_range(mhi, mlo);
    end
    if (o_tv && tr) begin
      tq.push_back(o_td);
      twait = $urandom_range(thi, tlo);
    end
    if (o_dn) ndone++;
    mpend = o_mv && !mr;
    pm = {1'b1, o_ma, o_mw, o_ms};
    tpend = o_tv && !tr;
    ptd = o_td;
    @(negedge clk);
  endtask

  task automatic run_frame(input bit sel, input bq_t junk, input bq_t pay,
                           input int ml, input int mh,
                           input int tl, input int th);
    int len;
    len = pay.size();
    fid++;
    s = sel;
    mlo = ml; mhi = mh; tlo = tl; thi = th;
    mwait = $urandom_range(mhi, mlo);
    twait = $urandom_range(thi, tlo);
    rxq = junk;
    rxq.push_back(8'hFE);
    for (int i = 0; i < 4; i++) rxq.push_back(8'(len >> (8 * i)));
    foreach (pay[i]) rxq.push_back(pay[i]);
    model(sel, pay);
    wq.delete();
    tq.delete();
    ndone = 0;
    for (int c = 0; c < 4000 && ndone == 0; c++) step();
    repeat (3) step();
    check("rx_drained", 64'(rxq.size()), 64'd0);
    check("n_writes", 64'(wq.size()), 64'(ew.size()));
    for (int i = 0; i < wq.size() && i < ew.size(); i++)
      check("write", 64'(wq[i]), 64'(ew[i]));
    check("n_reply", 64'(tq.size()), 64'd2);
    for (int i = 0; i < tq.size() && i < 2; i++)
      check("reply", 64'(tq[i]), 64'(et[i]));
    check("done_pulses", 64'(ndone), 64'd1);
    check("busy_end", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bq_t p, j;
    bit sel;
    int n;
    repeat (3) @(negedge clk);
    check("rst_rx_ready0", 64'(b0.rx_ready), 64'd0);
    check("rst_rx_ready1", 64'(b1.rx_ready), 64'd0);
    check("rst_tx_valid", 64'(b0.tx_valid), 64'd0);
    check("rst_mem_valid", 64'(b0.mem_valid), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_rx_ready0", 64'(b0.rx_ready), 64'd1);
    check("rel_rx_ready1", 64'(b1.rx_ready), 64'd1);
    check("rel_busy", 64'(busy0), 64'd0);

    j = {8'h41, 8'h00};
    p = {};
    for (int i = 1; i <= 8; i++) p.push_back(8'(i));
    run_frame(0, j, p, 0, 2, 0, 2);

    j = {};
    p = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_frame(0, j, p, 0, 1, 0, 1);

    p = {};
    run_frame(0, j, p, 0, 1, 0, 1);

    p = rand_bytes(68);
    run_frame(1, j, p, 0, 2, 0, 2);
    p = rand_bytes(64);
    run_frame(1, j, p, 0, 2, 0, 2);
    p = rand_bytes(65);
    run_frame(1, j, p, 0, 2, 0, 2);

    j = rand_junk(1);
    p = rand_bytes(13);
    run_frame(0, j, p, 3, 3, 2, 2);

    for (int f = 0; f < 12; f++) begin
      sel = bit'($urandom_range(0, 1));
      n = sel ? int'($urandom_range(56, 72)) : int'($urandom_range(0, 40));
      p = rand_bytes(n);
      j = rand_junk($urandom_range(0, 2));
      run_frame(sel, j, p, 0, $urandom_range(0, 3), 0, $urandom_range(0, 3));
    end

    // Abort a frame after six payload bytes
    fid++;
    s = 1'b0;
    mlo = 0; mhi = 2; tlo = 0; thi = 2;
    mwait = 0; twait = 0;
    p = rand_bytes(10);
    rxq = {8'hFE, 8'd10, 8'd0, 8'd0, 8'd0};
    foreach (p[i]) rxq.push_back(p[i]);
    nrx = 0;
    for (int c = 0; c < 500 && nrx < 11; c++) step();
    check("pre_reset_bytes", 64'(nrx), 64'd11);
    reset = 1'b0;
    rv = 1'b0; mr = 1'b0; tr = 1'b0;
    consumed = 0; mpend = 0; tpend = 0;
    rxq.delete();
    #1;
    check("abort_tx_valid", 64'(b0.tx_valid), 64'd0);
    check("abort_mem_valid", 64'(b0.mem_valid), 64'd0);
    check("abort_rx_ready", 64'(b0.rx_ready), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wq.delete();
    tq.delete();
    ndone = 0;
    repeat (6) step();
    check("post_rst_writes", 64'(wq.size()), 64'd0);
    check("post_rst_replies", 64'(tq.size()), 64'd0);
    check("post_rst_mv", 64'(o_mv), 64'd0);
    check("post_rst_rdy", 64'(o_rr), 64'd1);
    j = {};
    p = rand_bytes(11);
    run_frame(0, j, p, 0, 3, 0, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
